// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arbiter
// Description : Shares one 32-bit carry-lookahead adder between two
//               requesters (0 = ALU path, 1 = address/PC-offset path).
//               A round-robin arbiter accepts at most one operation per
//               cycle. The result, carry-out and signed overflow are held
//               in a single registered output slot that is tagged one-hot
//               to its owner. Per-requester counters count consumed results.
//
// Ports       : clock, clear          - clock, synchronous active-high reset
//               reqN_valid/ready      - request handshake, requester N
//               reqN_a, reqN_b        - 32-bit operands, requester N
//               reqN_sub              - 1 = A-B, 0 = A+B, requester N
//               resp_valid[1:0]       - one-hot, result pending for owner
//               resp_ready[1:0]       - bit N = requester N consumes result
//               resp_sum/cout/ovf     - registered result and flags
//               done_cnt0/done_cnt1   - results consumed per requester
//
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
    parameter int   CNT_W      = 16,
    parameter logic FIRST_PRIO = 1'b0
) (
    input  logic             clock,
    input  logic             clear,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_sub,

    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [31:0]      resp_sum,
    output logic             resp_cout,
    output logic             resp_ovf,

    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]       r_resp_valid;   // slot state: 0 = EMPTY, one-hot = FULL
    logic [31:0]      r_resp_sum;
    logic             r_resp_cout;
    logic             r_resp_ovf;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_done_cnt0;
    logic [CNT_W-1:0] r_done_cnt1;

    // ------------------------------------------------------------------
    // Slot drain / accept capability
    // ------------------------------------------------------------------
    logic [1:0] w_drain_vec;
    logic       w_drain;
    logic       w_can_accept;

    // Only the owner's ready bit can match, since resp_valid is one-hot.
    assign w_drain_vec  = r_resp_valid & resp_ready;
    assign w_drain      = |w_drain_vec;
    assign w_can_accept = (r_resp_valid == 2'b00) | w_drain;

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    logic w_gnt_valid;
    logic w_gnt_idx;
    logic w_accept;

    always_comb begin
        w_gnt_valid = req0_valid | req1_valid;
        if (req0_valid & req1_valid) begin
            w_gnt_idx = ~r_last_grant;
        end else begin
            w_gnt_idx = req1_valid;
        end
    end

    // Readiness is withheld while clear is high so nothing is accepted
    // on a reset edge.
    assign w_accept   = w_can_accept & w_gnt_valid & ~clear;
    assign req0_ready = w_accept & ~w_gnt_idx;
    assign req1_ready = w_accept &  w_gnt_idx;

    // ------------------------------------------------------------------
    // Operand select and subtract conditioning
    // ------------------------------------------------------------------
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_sub;
    logic [31:0] w_b_eff;

    assign w_a     = w_gnt_idx ? req1_a   : req0_a;
    assign w_b     = w_gnt_idx ? req1_b   : req0_b;
    assign w_sub   = w_gnt_idx ? req1_sub : req0_sub;
    assign w_b_eff = w_sub ? ~w_b : w_b;

    // ------------------------------------------------------------------
    // 32-bit carry-lookahead adder: full lookahead inside each 4-bit
    // group, group generate/propagate used to pass the carry between
    // groups.
    // ------------------------------------------------------------------
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_carry;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_ovf;

    assign w_g = w_a & w_b_eff;
    assign w_p = w_a ^ w_b_eff;

    always_comb begin
        w_carry    = '0;
        w_carry[0] = w_sub;
        for (int k = 0; k < 8; k++) begin
            w_carry[4*k+1] = w_g[4*k]
                           | (w_p[4*k]   & w_carry[4*k]);
            w_carry[4*k+2] = w_g[4*k+1]
                           | (w_p[4*k+1] & w_g[4*k])
                           | (w_p[4*k+1] & w_p[4*k] & w_carry[4*k]);
            w_carry[4*k+3] = w_g[4*k+2]
                           | (w_p[4*k+2] & w_g[4*k+1])
                           | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                           | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_carry[4*k]);
            // Group generate | group propagate & group carry-in
            w_carry[4*k+4] = (w_g[4*k+3]
                           | (w_p[4*k+3] & w_g[4*k+2])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]))
                           | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k]
                              & w_carry[4*k]);
        end
    end

    assign w_sum  = w_p ^ w_carry[31:0];
    assign w_cout = w_carry[32];
    // Signed overflow: same-sign operands giving a different-sign result.
    assign w_ovf  = (w_a[31] == w_b_eff[31]) & (w_sum[31] != w_a[31]);

    // ------------------------------------------------------------------
    // Output slot, arbitration history and completion counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_resp_valid <= 2'b00;
            r_resp_sum   <= '0;
            r_resp_cout  <= 1'b0;
            r_resp_ovf   <= 1'b0;
            r_last_grant <= ~FIRST_PRIO;
            r_done_cnt0  <= '0;
            r_done_cnt1  <= '0;
        end else begin
            if (w_accept) begin
                r_resp_valid <= w_gnt_idx ? 2'b10 : 2'b01;
                r_resp_sum   <= w_sum;
                r_resp_cout  <= w_cout;
                r_resp_ovf   <= w_ovf;
                r_last_grant <= w_gnt_idx;
            end else if (w_drain) begin
                r_resp_valid <= 2'b00;
            end

            if (w_drain_vec[0]) begin
                r_done_cnt0 <= r_done_cnt0 + 1'b1;
            end
            if (w_drain_vec[1]) begin
                r_done_cnt1 <= r_done_cnt1 + 1'b1;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_sum   = r_resp_sum;
    assign resp_cout  = r_resp_cout;
    assign resp_ovf   = r_resp_ovf;
    assign done_cnt0  = r_done_cnt0;
    assign done_cnt1  = r_done_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_arbiter
// Description : Self-checking bench for adder_share_arbiter. Directed steps
//               followed by randomized traffic, compared every cycle against
//               a behavioural model built from plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

    localparam int   CNT_W = 8;
    localparam logic FP    = 1'b0;

    logic             clock;
    logic             clear;
    logic             req0_valid, req0_ready, req0_sub;
    logic [31:0]      req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_sub;
    logic [31:0]      req1_a, req1_b;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [31:0]      resp_sum;
    logic             resp_cout;
    logic             resp_ovf;
    logic [CNT_W-1:0] done_cnt0;
    logic [CNT_W-1:0] done_cnt1;

    adder_share_arbiter #(.CNT_W(CNT_W), .FIRST_PRIO(FP)) dut (
        .clock      (clock),
        .clear      (clear),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    logic [1:0]  m_valid = 2'b00;
    logic [31:0] m_sum   = '0;
    logic        m_cout  = 1'b0;
    logic        m_ovf   = 1'b0;
    int          m_owner_last = 0;     // requester granted most recently
    int          m_cnt0  = 0;
    int          m_cnt1  = 0;
    logic        acc0, acc1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: unsigned and signed results from integers.
    task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] s, output logic c, output logic o);
        longint sa, sb, r;
        logic [32:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            u = {1'b0, a} - {1'b0, b};
            c = (a >= b);
            r = sa - sb;
        end else begin
            u = {1'b0, a} + {1'b0, b};
            c = u[32];
            r = sa + sb;
        end
        s = u[31:0];
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    // One clock: inputs are already driven; check ready mid-cycle, advance
    // the model at the edge, then check the registered outputs.
    task automatic step();
        logic e_r0, e_r1, drained, can, g_idx;
        logic [31:0] s;
        logic c, o;
        #3;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        drained = |(m_valid & resp_ready);
        can = (m_valid == 2'b00) || drained;
        if (!clear && can) begin
            if (req0_valid && req1_valid) g_idx = (m_owner_last == 0);
            else                          g_idx = req1_valid;
            e_r0 = req0_valid && !g_idx;
            e_r1 = req1_valid &&  g_idx;
        end
        chk("req0_ready", 64'(req0_ready), 64'(e_r0));
        chk("req1_ready", 64'(req1_ready), 64'(e_r1));
        acc0 = e_r0;
        acc1 = e_r1;
        @(posedge clock);
        if (clear) begin
            m_valid = 2'b00; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
            m_owner_last = (FP == 1'b0) ? 1 : 0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            if (m_valid[0] && resp_ready[0]) m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
            if (m_valid[1] && resp_ready[1]) m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
            if (acc0) begin
                ref_op(req0_a, req0_b, req0_sub, s, c, o);
                m_sum = s; m_cout = c; m_ovf = o; m_valid = 2'b01; m_owner_last = 0;
            end else if (acc1) begin
                ref_op(req1_a, req1_b, req1_sub, s, c, o);
                m_sum = s; m_cout = c; m_ovf = o; m_valid = 2'b10; m_owner_last = 1;
            end else if (drained) begin
                m_valid = 2'b00;
            end
        end
        #1;
        chk("resp_valid", 64'(resp_valid), 64'(m_valid));
        chk("resp_sum",   64'(resp_sum),   64'(m_sum));
        chk("resp_cout",  64'(resp_cout),  64'(m_cout));
        chk("resp_ovf",   64'(resp_ovf),   64'(m_ovf));
        chk("done_cnt0",  64'(done_cnt0),  64'(m_cnt0));
        chk("done_cnt1",  64'(done_cnt1),  64'(m_cnt1));
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
    endtask

    initial begin
        clear = 1'b1;
        resp_ready = 2'b00;
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b0, '0, '0, 1'b0);
        @(posedge clock); #1;

        // Reset state
        step();
        step();
        clear = 1'b0;

        // Single add on requester 0, then drain
        resp_ready = 2'b01;
        drive0(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0);
        step();
        chk("add_sum", 64'(resp_sum), 64'h8);
        drive0(1'b0, '0, '0, 1'b0);
        step();
        chk("add_cnt0", 64'(done_cnt0), 64'd1);

        // Subtract and flag cases on requester 1
        resp_ready = 2'b10;
        drive1(1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1);
        step();
        chk("sub_sum", 64'(resp_sum), 64'hFFFF_FFFE);
        drive1(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        step();
        chk("ovf_flag", 64'(resp_ovf), 64'd1);
        drive1(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        step();
        chk("cout_flag", 64'(resp_cout), 64'd1);
        drive1(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);
        step();
        drive1(1'b0, '0, '0, 1'b0);
        step();

        // Round-robin from reset: both valid, alternate grants
        clear = 1'b1;
        step();
        clear = 1'b0;
        resp_ready = 2'b11;
        for (int i = 0; i < 20; i++) begin
            if (i == 0 || acc0) drive0(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            if (i == 0 || acc1) drive1(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            step();
        end
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b0, '0, '0, 1'b0);
        step();
        chk("rr_cnt_equal", 64'(done_cnt0), 64'(done_cnt1));

        // Backpressure: slot full for requester 0, requester 1 waits
        resp_ready = 2'b00;
        drive0(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        step();
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1);
        for (int i = 0; i < 3; i++) begin
            resp_ready = 2'b10;   // non-owner ready is ignored
            step();
            chk("bp_hold_sum", 64'(resp_sum), 64'h2345_6789);
        end
        resp_ready = 2'b01;
        step();
        chk("bp_handoff", 64'(resp_valid), 64'h2);
        drive1(1'b0, '0, '0, 1'b0);
        resp_ready = 2'b10;
        step();

        // Randomized traffic with operand hold while pending
        for (int i = 0; i < 400; i++) begin
            if (!(req0_valid && !acc0))
                drive0(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            if (!(req1_valid && !acc1))
                drive1(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            resp_ready = 2'($urandom_range(0, 3));
            step();
        end

        // Reset mid-operation with slot full and both requesters valid
        resp_ready = 2'b00;
        drive0(1'b1, 32'h0000_00AA, 32'h0000_0055, 1'b0);
        drive1(1'b0, '0, '0, 1'b0);
        step();
        step();
        drive1(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0);
        clear = 1'b1;
        step();
        chk("rst_valid", 64'(resp_valid), 64'h0);
        clear = 1'b0;
        step();
        chk("rst_first_tie", 64'(resp_valid), 64'(FP ? 2'b10 : 2'b01));

        // Counter wrap: 2^CNT_W drains on requester 0
        clear = 1'b1;
        drive1(1'b0, '0, '0, 1'b0);
        step();
        clear = 1'b0;
        resp_ready = 2'b01;
        for (int i = 0; i < (1 << CNT_W); i++) begin
            drive0(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            step();
        end
        drive0(1'b0, '0, '0, 1'b0);
        step();
        chk("wrap_cnt0", 64'(done_cnt0), 64'h0);
        chk("wrap_cnt1", 64'(done_cnt1), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one add_32_bit carry-lookahead adder between two requesters (requester 0 = ALU path, requester 1 = address/PC-offset path).
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- A round-robin arbiter grants one request per cycle. Subtraction is done by inverting B and setting carry-in.
- The result is registered in a single output slot and returned to the granted requester one cycle after acceptance. The block also keeps per-requester completion counters.

Parameters:
- CNT_W, 16, width of per-requester completion counters (wrap on overflow).
- FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  32  operand A, requester 0
- req0_b  in  32  operand B, requester 0
- req0_sub  in  1  1 = A-B, 0 = A+B, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as above, requester 1
- resp_valid  out  2  one-hot; bit n = result pending for requester n
- resp_ready  in  2  bit n = requester n consumes its result
- resp_sum  out  32  registered result
- resp_cout  out  1  registered carry-out of the adder
- resp_ovf  out  1  registered signed overflow
- done_cnt0  out  CNT_W  results consumed by requester 0
- done_cnt1  out  CNT_W  results consumed by requester 1

Behaviour:
- Reset (clear=1 at rising edge):
  - resp_valid=0; resp_sum=0, resp_cout=0, resp_ovf=0.
  - done_cnt0=done_cnt1=0; last_grant=~FIRST_PRIO.
  - Reset wins over all other events. A pending result is discarded with no response and no count.
- Slot states: EMPTY (resp_valid==0) and FULL (one resp_valid bit set, owner = that requester).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on simultaneous drain and accept.
- drain = |(resp_valid & resp_ready).
- can_accept = EMPTY or drain (full throughput, one operation per cycle).
- Grant, combinational:
  - Only reqN_valid set: grant N.
  - Both set: grant ~last_grant.
  - Neither set: no grant.
- reqN_ready = can_accept & (grant==N). reqN_ready may depend on the other requester's valid. reqN_valid must never depend on reqN_ready.
- Accept = reqN_valid & reqN_ready. On accept, last_grant<=N.
- Requesters hold a, b, sub stable while valid=1 and ready=0. Dropping valid before acceptance is permitted; no state changes.
- Datapath for the granted requester:
  - b_eff = sub ? ~b : b; cin = sub; {cout,sum} = add_32_bit(a, b_eff, cin).
  - ovf = (a[31]==b_eff[31]) & (sum[31]!=a[31]).
  - On accept, resp_sum, resp_cout and resp_ovf are registered and resp_valid<=one-hot(N). Latency is one cycle, accept edge to resp_valid.
- Output slot hold:
  - While FULL and not drained, resp_sum, resp_cout, resp_ovf and resp_valid hold.
  - Data outputs keep their last value when EMPTY.
  - resp_ready bits for a non-owner are ignored.
- Counters: done_cntN increments by 1 on each drain by requester N and wraps from 2^CNT_W-1 to 0.
- Arithmetic: modulo 2^32. cout for subtraction is the not-borrow (A>=B unsigned gives cout=1).

Test Plan:
- Single add: after reset, req0 a=0x0000_0005 b=0x0000_0003 sub=0, resp_ready=2'b01 -> req0_ready=1 same cycle; next cycle resp_valid=2'b01, sum=0x0000_0008, cout=0, ovf=0; done_cnt0=1 after drain.
- Subtract/flags: req1 a=0x0000_0003 b=0x0000_0005 sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0. Then a=0x7FFF_FFFF b=0x0000_0001 sub=0 -> sum=0x8000_0000, ovf=1. Then a=0xFFFF_FFFF b=1 add -> sum=0, cout=1.
- Round-robin, FIRST_PRIO=0: both valid continuously, resp_ready=2'b11 -> grants 0,1,0,1,... one accept per cycle, each result tagged to the correct resp_valid bit; counters equal after 2k cycles.
- Backpressure: slot FULL for req0, resp_ready=0 for 3 cycles with req1_valid=1 -> req1_ready=0 and outputs stable for 3 cycles. Raising resp_ready[0] gives drain and req1 accept in the same cycle; next cycle resp_valid=2'b10.
- Reset mid-op: clear=1 while slot FULL and both valid -> next cycle resp_valid=0, counters 0, no ready asserted during clear. First tie after release is granted to FIRST_PRIO.
- Counter wrap: force 2^CNT_W drains on req0 -> done_cnt0 returns to 0; done_cnt1 unaffected.
